mu_data_ram: RTL and testbench
==============================

# mu_data_ram

Parametrised data memory for the multicycle MIPS datapath, sitting between the memory-stage address/store-data registers and the load-data register. It maps a window of `DEPTH_WORDS` words starting at `BASE_ADDR` and supports byte, halfword and word stores. Loads are sign- or zero-extended, with a configurable pipelined read latency. It flags misaligned and out-of-window accesses, and can clear its contents after reset through an internal initialisation sequencer.

## Interface
- `DATA_WIDTH`, 32: word width; addresses share this width.
- `DEPTH_WORDS`, 64: number of words; a power of two, at least 4.
- `BASE_ADDR`, 32'h1001_0000: byte address of word 0; word-aligned.
- `RD_LATENCY`, 1: cycles from read acceptance to `rd_valid`; legal values are 1 and 2.
- `CLEAR_ON_RESET`, 1: when 1, the block zeroes every word after reset.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: access request, qualified by `ready`.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `load_unsigned` in 1: 1 = zero-extend sub-word loads, 0 = sign-extend.
- `addr` in DATA_WIDTH: byte address.
- `wr_data` in DATA_WIDTH: store data, right-justified (byte in [7:0], half in [15:0]).
- `ready` out 1: block accepts a request this cycle.
- `rd_valid` out 1: `rd_data` is valid this cycle (one-cycle pulse per load).
- `rd_data` out DATA_WIDTH: extended load result.
- `err_align` out 1: one-cycle pulse, the access was misaligned or had reserved `size`.
- `err_range` out 1: one-cycle pulse, the address was outside the window.
- `init_busy` out 1: the clear sequence is running.

## Operation
- **States.** The sequencer has two states, INIT and RUN.
  - `reset` moves it to INIT if `CLEAR_ON_RESET=1`, otherwise to RUN.
  - INIT writes 0 to word index k, k = 0 up to DEPTH_WORDS-1, one word per cycle. It enters RUN after the last word.
  - In INIT: `init_busy=1` and `ready=0`. In RUN: `init_busy=0` and `ready=1`.
- **Acceptance.** An access is accepted when `req & ready`. One access can be accepted per cycle, so loads are fully pipelined.
- **Indexing.** Offset = `addr - BASE_ADDR` (DATA_WIDTH-bit subtraction). Word index = offset >> 2. Lane = offset[1:0].
- **Byte order.** Little-endian: lane 0 is bits [7:0].
- **Range check.** `err_range` when `addr < BASE_ADDR` (unsigned) or offset ≥ 4*DEPTH_WORDS.
- **Alignment check.** `err_align` when size=01 and offset[0]=1, when size=10 and offset[1:0]≠0, or when size=11.
- **Errored accesses.** If both checks fail, both flags assert. An errored store writes nothing. An errored load still produces `rd_valid`, with `rd_data=0`.
- **Stores.** Only the addressed lanes are written: one byte for size=00, lanes {1,0} or {3,2} for size=01, all four for size=10. Other lanes keep their value.
- **Loads.** The addressed byte or half is extracted, then extended to DATA_WIDTH per `load_unsigned`. A word load returns the raw word.
- **Read-after-write.** A load accepted the cycle after a store to the same word returns the updated data.
- **Simultaneous access.** One port only, so a load and a store are never accepted in the same cycle.
- **Reset mid-operation.** Reset discards in-flight loads and pending error flags: no `rd_valid` or `err_*` appears for them. It restarts INIT from word 0.
- **Contents across reset.** With `CLEAR_ON_RESET=0`, memory contents survive reset.

## Timing
- **Reset values:** `rd_valid=0`, `rd_data=0`, `err_align=0`, `err_range=0`.
  - `CLEAR_ON_RESET=1`: `ready=0` and `init_busy=1` starting the cycle after `reset` is sampled high.
  - `CLEAR_ON_RESET=0`: `ready=1` and `init_busy=0`.
- **INIT duration:** exactly DEPTH_WORDS cycles. `ready` rises on the first cycle after the final clear write.
- **Store:** the write takes effect at the accepting edge. `err_*` pulse in cycle T+1 for a store accepted in cycle T.
- **Load:** a load accepted in cycle T gives `rd_valid`, `rd_data` and `err_*` in cycle T+RD_LATENCY.
- **Output hold:** `rd_data` holds its last value when `rd_valid=0`.
- **Back-to-back loads:** N loads give N consecutive `rd_valid` pulses.

## Test plan
- **Reset clear.** With CLEAR_ON_RESET=1 and DEPTH_WORDS=64, pulse reset. Require `ready=0` for exactly 64 cycles. Then a word load of 0x1001_00FC returns 0x0000_0000.
- **Byte stores.** Word store 0x1122_3344 to 0x1001_0010, then byte store 0xAB to 0x1001_0012. A word load then returns 0x11AB_3344. A signed byte load of 0x1001_0012 returns 0xFFFF_FFAB; an unsigned one returns 0x0000_00AB.
- **Halfword stores.** Half store 0x8001 to 0x1001_0006. A signed half load returns 0xFFFF_8001; an unsigned one returns 0x0000_8001.
- **Error flags.**
  - Word load at 0x1001_0002: `err_align` pulses and `rd_data=0`.
  - Word store at 0x1000_FFFC: `err_range` pulses and memory is unchanged.
  - Load at 0x1001_0100 (DEPTH 64): `err_range` pulses.
- **Pipelining and RAW.** With RD_LATENCY=2, issue 4 back-to-back loads. Require 4 consecutive `rd_valid` pulses starting at T+2. A store followed next cycle by a load to the same word returns the new data.
- **Reset mid-operation.** Assert reset while 2 loads are in flight. Require no `rd_valid` and INIT restarting at word 0.

Source files
------------

// File: rtl/mu_data_ram.sv
// Windowed data RAM for the multicycle MIPS datapath: byte/half/word stores,
// sign/zero-extended pipelined loads, alignment/range flags and a post-reset clear sequencer.
module mu_data_ram #(
    parameter int unsigned              DATA_WIDTH     = 32,
    parameter int unsigned              DEPTH_WORDS    = 64,
    parameter logic [DATA_WIDTH-1:0]    BASE_ADDR      = 32'h1001_0000,
    parameter int unsigned              RD_LATENCY     = 1,
    parameter int unsigned              CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  load_unsigned,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err_align,
    output logic                  err_range,
    output logic                  init_busy
);

    localparam int unsigned           IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [DATA_WIDTH-1:0] WIN_BYTES = DATA_WIDTH'(4 * DEPTH_WORDS);
    localparam logic [0:0]            S_INIT    = 1'b0;
    localparam logic [0:0]            S_RUN     = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             init_wr_c;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // Clear sequencer state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_wr_c = 1'b0;
        case (state_q)
            S_INIT: begin
                init_wr_c = 1'b1;
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d = S_RUN;
                end
            end
            default: ;
        endcase
    end

    assign ready     = (state_q == S_RUN);
    assign init_busy = (state_q == S_INIT);

    // Address decode and access checks
    logic [DATA_WIDTH-1:0] offset;
    logic [1:0]            lane;
    logic [IDX_W-1:0]      widx;
    logic                  range_err, align_err, any_err;
    logic                  acc_ld, acc_st, st_wr;

    assign offset    = addr - BASE_ADDR;
    assign lane      = offset[1:0];
    assign widx      = offset[IDX_W+1:2];
    assign range_err = (addr < BASE_ADDR) || (offset >= WIN_BYTES);
    assign any_err   = range_err | align_err;
    assign acc_ld    = req & ready & ~we;
    assign acc_st    = req & ready & we;
    assign st_wr     = acc_st & ~any_err;

    always_comb begin
        align_err = 1'b0;
        case (size)
            2'b01:   align_err = offset[0];
            2'b10:   align_err = |offset[1:0];
            2'b11:   align_err = 1'b1;
            default: align_err = 1'b0;
        endcase
    end

    // Lane enables and right-justified store data replicated onto every lane
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wr_rep;

    always_comb begin
        be     = 4'b0000;
        wr_rep = wr_data;
        case (size)
            2'b00: begin
                be     = 4'b0001 << lane;
                wr_rep = DATA_WIDTH'({4{wr_data[7:0]}});
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wr_rep = DATA_WIDTH'({2{wr_data[15:0]}});
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_wr_c) begin
                mem_q[cnt_q] <= '0;
            end else if (st_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[widx][8*b +: 8] <= wr_rep[8*b +: 8];
                    end
                end
            end
        end
    end

    // Load extraction and extension; errored loads return zero
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_result;

    assign rd_word = mem_q[widx];
    assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (lane)
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            2'd3:    ld_byte = rd_word[31:24];
            default: ld_byte = rd_word[7:0];
        endcase
    end

    always_comb begin
        case (size)
            2'b00:   ld_result = load_unsigned ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                               : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            2'b01:   ld_result = load_unsigned ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                               : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            default: ld_result = rd_word;
        endcase
        if (any_err) begin
            ld_result = '0;
        end
    end

    // Final-stage inputs: directly from the access for latency 1, via one extra register for 2
    logic                  fin_v_c;
    logic [DATA_WIDTH-1:0] fin_data_c;
    logic                  fin_ea_c, fin_er_c;

    if (RD_LATENCY >= 2) begin : g_lat2
        logic                  p_v_q, p_ea_q, p_er_q;
        logic [DATA_WIDTH-1:0] p_data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                p_v_q    <= 1'b0;
                p_ea_q   <= 1'b0;
                p_er_q   <= 1'b0;
                p_data_q <= '0;
            end else begin
                p_v_q    <= acc_ld;
                p_ea_q   <= acc_ld & align_err;
                p_er_q   <= acc_ld & range_err;
                p_data_q <= ld_result;
            end
        end

        assign fin_v_c    = p_v_q;
        assign fin_data_c = p_data_q;
        assign fin_ea_c   = p_ea_q;
        assign fin_er_c   = p_er_q;
    end else begin : g_lat1
        assign fin_v_c    = acc_ld;
        assign fin_data_c = ld_result;
        assign fin_ea_c   = acc_ld & align_err;
        assign fin_er_c   = acc_ld & range_err;
    end

    // Output registers; store errors always report one cycle after acceptance
    logic                  rd_valid_q, err_align_q, err_range_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            rd_valid_q  <= fin_v_c;
            if (fin_v_c) begin
                rd_data_q <= fin_data_c;
            end
            err_align_q <= fin_ea_c | (acc_st & align_err);
            err_range_q <= fin_er_c | (acc_st & range_err);
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign err_align = err_align_q;
    assign err_range = err_range_q;

endmodule

// File: tb/tb_mu_data_ram.sv
// Directed bench for mu_data_ram: one instance at read latency 1 and one at latency 2,
// driven by the same stimulus and checked against hand-computed values.
module tb_mu_data_ram;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wr_data;

    logic        r1_ready, r1_rd_valid, r1_err_align, r1_err_range, r1_init_busy;
    logic [31:0] r1_rd_data;
    logic        r2_ready, r2_rd_valid, r2_err_align, r2_err_range, r2_init_busy;
    logic [31:0] r2_rd_data;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    mu_data_ram #(.RD_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .load_unsigned(load_unsigned), .addr(addr), .wr_data(wr_data),
        .ready(r1_ready), .rd_valid(r1_rd_valid), .rd_data(r1_rd_data),
        .err_align(r1_err_align), .err_range(r1_err_range), .init_busy(r1_init_busy)
    );

    mu_data_ram #(.RD_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .load_unsigned(load_unsigned), .addr(addr), .wr_data(wr_data),
        .ready(r2_ready), .rd_valid(r2_rd_valid), .rd_data(r2_rd_data),
        .err_align(r2_err_align), .err_range(r2_err_range), .init_busy(r2_init_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Counts ready-low samples until ready rises; nothing else may fire meanwhile
    task automatic wait_init(input string tag);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (r1_ready !== 1'b1 && n < 200) begin
            n++;
            if (r1_rd_valid | r2_rd_valid | r1_err_align | r2_err_align |
                r1_err_range | r2_err_range | (r2_ready !== r1_ready) | (r1_init_busy !== 1'b1))
                seen = 1'b1;
            @(posedge clk); #1;
        end
        chk({tag, ".len"}, 32'(n), 32'd64);
        chk({tag, ".quiet"}, 32'(seen), 32'd0);
        chk({tag, ".busy_off"}, 32'(r1_init_busy), 32'd0);
        chk({tag, ".ready2"}, 32'(r2_ready), 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] exp, input logic ea, input logic er);
        req = 1'b1; we = 1'b0; size = sz; load_unsigned = uns; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
        chk({tag, ".v1"},  32'(r1_rd_valid), 32'd1);
        chk({tag, ".d1"},  r1_rd_data, exp);
        chk({tag, ".ea1"}, 32'(r1_err_align), 32'(ea));
        chk({tag, ".er1"}, 32'(r1_err_range), 32'(er));
        chk({tag, ".v2early"}, 32'(r2_rd_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".v2"},  32'(r2_rd_valid), 32'd1);
        chk({tag, ".d2"},  r2_rd_data, exp);
        chk({tag, ".ea2"}, 32'(r2_err_align), 32'(ea));
        chk({tag, ".er2"}, 32'(r2_err_range), 32'(er));
        chk({tag, ".hold1"}, {r1_rd_valid, r1_rd_data[30:0]}, {1'b0, exp[30:0]});
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d, input logic ea, input logic er);
        req = 1'b1; we = 1'b1; size = sz; addr = a; wr_data = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        chk({tag, ".ea"}, {30'd0, r1_err_align, r2_err_align}, {30'd0, ea, ea});
        chk({tag, ".er"}, {30'd0, r1_err_range, r2_err_range}, {30'd0, er, er});
        chk({tag, ".nov"}, {30'd0, r1_rd_valid, r2_rd_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, {28'd0, r1_err_align, r2_err_align, r1_err_range, r2_err_range}, 32'd0);
    endtask

    // Store in one cycle, load the same word the very next cycle
    task automatic raw(input string tag, input logic [31:0] sa, input logic [1:0] ssz,
                       input logic [31:0] d, input logic [31:0] la, input logic [31:0] exp);
        req = 1'b1; we = 1'b1; size = ssz; addr = sa; wr_data = d;
        @(posedge clk); #1;
        we = 1'b0; size = SZ_W; addr = la; load_unsigned = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk({tag, ".d1"}, {r1_rd_valid, r1_rd_data[30:0]}, {1'b1, exp[30:0]});
        chk({tag, ".d1full"}, r1_rd_data, exp);
        @(posedge clk); #1;
        chk({tag, ".d2"}, r2_rd_data, exp);
        chk({tag, ".v2"}, 32'(r2_rd_valid), 32'd1);
    endtask

    logic [31:0] pa [4];
    logic [1:0]  ps [4];
    logic [31:0] pe [4];

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; size = SZ_W;
        load_unsigned = 1'b0; addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready",  {30'd0, r1_ready, r2_ready}, 32'd0);
        chk("rst.busy",   {30'd0, r1_init_busy, r2_init_busy}, 32'd3);
        chk("rst.valid",  {30'd0, r1_rd_valid, r2_rd_valid}, 32'd0);
        chk("rst.data1",  r1_rd_data, 32'd0);
        chk("rst.data2",  r2_rd_data, 32'd0);
        chk("rst.err",    {28'd0, r1_err_align, r2_err_align, r1_err_range, r2_err_range}, 32'd0);
        reset = 1'b0;
        wait_init("init");

        do_load("clr_top", 32'h1001_00FC, SZ_W, 1'b0, 32'h0000_0000, 1'b0, 1'b0);

        do_store("st_w",  32'h1001_0010, SZ_W, 32'h1122_3344, 1'b0, 1'b0);
        do_store("st_b",  32'h1001_0012, SZ_B, 32'hDEAD_BEAB, 1'b0, 1'b0);
        do_load("ld_w",   32'h1001_0010, SZ_W, 1'b0, 32'h11AB_3344, 1'b0, 1'b0);
        do_load("ld_bs",  32'h1001_0012, SZ_B, 1'b0, 32'hFFFF_FFAB, 1'b0, 1'b0);
        do_load("ld_bu",  32'h1001_0012, SZ_B, 1'b1, 32'h0000_00AB, 1'b0, 1'b0);
        do_load("ld_b3",  32'h1001_0013, SZ_B, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
        do_load("ld_b0",  32'h1001_0010, SZ_B, 1'b0, 32'h0000_0044, 1'b0, 1'b0);

        do_store("st_h",  32'h1001_0006, SZ_H, 32'hFFFF_8001, 1'b0, 1'b0);
        do_load("ld_hs",  32'h1001_0006, SZ_H, 1'b0, 32'hFFFF_8001, 1'b0, 1'b0);
        do_load("ld_hu",  32'h1001_0006, SZ_H, 1'b1, 32'h0000_8001, 1'b0, 1'b0);
        do_load("ld_hw",  32'h1001_0004, SZ_W, 1'b0, 32'h8001_0000, 1'b0, 1'b0);

        do_load("e_walgn",  32'h1001_0002, SZ_W, 1'b0, 32'h0, 1'b1, 1'b0);
        do_store("e_stlow", 32'h1000_FFFC, SZ_W, 32'h1234_5678, 1'b0, 1'b1);
        do_load("e_unchg",  32'h1001_00FC, SZ_W, 1'b0, 32'h0, 1'b0, 1'b0);
        do_load("e_high",   32'h1001_0100, SZ_W, 1'b0, 32'h0, 1'b0, 1'b1);
        do_load("e_both",   32'h1001_0101, SZ_H, 1'b0, 32'h0, 1'b1, 1'b1);
        do_load("e_halgn",  32'h1001_0007, SZ_H, 1'b0, 32'h0, 1'b1, 1'b0);
        do_load("e_rsvld",  32'h1001_0010, SZ_X, 1'b0, 32'h0, 1'b1, 1'b0);
        do_store("e_rsvst", 32'h1001_0010, SZ_X, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_load("e_keep",   32'h1001_0010, SZ_W, 1'b0, 32'h11AB_3344, 1'b0, 1'b0);

        do_store("st_w0", 32'h1001_0000, SZ_W, 32'hCAFE_F00D, 1'b0, 1'b0);
        pa[0] = 32'h1001_0010; ps[0] = SZ_W; pe[0] = 32'h11AB_3344;
        pa[1] = 32'h1001_0004; ps[1] = SZ_W; pe[1] = 32'h8001_0000;
        pa[2] = 32'h1001_0000; ps[2] = SZ_W; pe[2] = 32'hCAFE_F00D;
        pa[3] = 32'h1001_0003; ps[3] = SZ_B; pe[3] = 32'h0000_00CA;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                req = 1'b1; we = 1'b0; addr = pa[i]; size = ps[i]; load_unsigned = 1'b1;
            end else begin
                req = 1'b0;
            end
            @(posedge clk); #1;
            chk("pipe.v1", 32'(r1_rd_valid), 32'(i < 4));
            if (i < 4) chk("pipe.d1", r1_rd_data, pe[i]);
            chk("pipe.v2", 32'(r2_rd_valid), 32'(i >= 1 && i < 5));
            if (i >= 1 && i < 5) chk("pipe.d2", r2_rd_data, pe[i-1]);
        end

        raw("raw_w", 32'h1001_0020, SZ_W, 32'h5A5A_1234, 32'h1001_0020, 32'h5A5A_1234);
        raw("raw_b", 32'h1001_0021, SZ_B, 32'h0000_0077, 32'h1001_0020, 32'h5A5A_7734);

        // Reset lands while loads are still in the pipeline
        req = 1'b1; we = 1'b0; size = SZ_W; addr = 32'h1001_0002;
        @(posedge clk); #1;
        chk("mid.l1_v1",  32'(r1_rd_valid), 32'd1);
        chk("mid.l1_ea1", 32'(r1_err_align), 32'd1);
        addr = 32'h1001_0100; reset = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; reset = 1'b0;
        chk("mid.valid", {30'd0, r1_rd_valid, r2_rd_valid}, 32'd0);
        chk("mid.err",   {28'd0, r1_err_align, r2_err_align, r1_err_range, r2_err_range}, 32'd0);
        chk("mid.data",  r1_rd_data, 32'd0);
        wait_init("mid_init");
        do_load("mid_clr", 32'h1001_0010, SZ_W, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset partway through INIT restarts the full clear
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("reinit.busy", 32'(r1_init_busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_init("reinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
